wb_retire_unit: RTL and testbench

Parameterised write-back/retire unit that generalises the single-path WB stage to NUM_CH producer channels (e.g. ALU, load unit, link/jump unit).
- Each channel pushes completed results into its own small FIFO under valid/ready.
- A round-robin arbiter retires one entry per cycle to the register file's single write port.
- Load results are aligned and extended per entry (byte/half/word, signed/unsigned, big-endian).
- The block latches halt, counts retirements, and sits between the MEM stage producers and the register file.

---
 rtl/wb_pkg.sv | 36 +++
 rtl/wb_ch_fifo.sv | 40 ++++
 rtl/wb_retire_unit.sv | 106 ++++++++++
 tb/tb_wb_retire_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared entry type, load modes and big-endian load alignment for wb_retire_unit.
package wb_pkg;
  localparam int WB_DMAX = 64;
  localparam int WB_AMAX = 8;
  localparam int WB_IW = $clog2(WB_DMAX);
  typedef enum logic [2:0] {
    LD_WORD   = 3'd0,
    LD_BYTE_S = 3'd1,
    LD_BYTE_U = 3'd2,
    LD_HALF_S = 3'd3,
    LD_HALF_U = 3'd4
  } ld_mode_e;
  typedef struct packed {
    logic [WB_DMAX-1:0] data;
    logic [WB_AMAX-1:0] rd;
    ld_mode_e           mode;
    logic [1:0]         boff;
    logic               halt;
  } wb_entry_t;
  // Byte 0 is the most significant byte of the xlen-bit word; unknown modes pass through.
  function automatic logic [WB_DMAX-1:0] wb_extend(input logic [WB_DMAX-1:0] d, input ld_mode_e m,
                                                   input logic [1:0] boff, input int xlen);
    logic [WB_IW-1:0] bi;
    logic [WB_IW-1:0] hi;
    logic [7:0] b;
    logic [15:0] h;
    bi = WB_IW'(xlen - 1 - 8 * int'(boff));
    hi = WB_IW'(xlen - 1 - 16 * int'(boff[1]));
    b = d[bi -: 8];
    h = d[hi -: 16];
    return m == LD_BYTE_S ? {{(WB_DMAX-8){b[7]}}, b} :
           m == LD_BYTE_U ? {{(WB_DMAX-8){1'b0}}, b} :
           m == LD_HALF_S ? {{(WB_DMAX-16){h[15]}}, h} :
           m == LD_HALF_U ? {{(WB_DMAX-16){1'b0}}, h} : d;
  endfunction
endpackage

// File: rtl/wb_ch_fifo.sv
// wb_ch_fifo: per-channel synchronous FIFO of wb_entry_t with full/empty flags and occupancy count.
module wb_ch_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     push_i,
  input  wb_entry_t                din_i,
  input  logic                     pop_i,
  output wb_entry_t                dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  wb_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rp_q];
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_q + AW'(do_push);
      rp_q  <= rp_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q] <= din_i;
endmodule

// File: rtl/wb_retire_unit.sv
// wb_retire_unit: NUM_CH producer FIFOs, round-robin retire to one register-file write port.
// Define WB_TRACE_EN to print one trace line per retirement.
module wb_retire_unit
  import wb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*XLEN-1:0]   in_data,
  input  logic [NUM_CH*REG_AW-1:0] in_rd,
  input  logic [NUM_CH*3-1:0]      in_ld_mode,
  input  logic [NUM_CH*2-1:0]      in_boff,
  input  logic [NUM_CH-1:0]        in_halt,
  output logic                     rf_we,
  output logic [REG_AW-1:0]        rf_waddr,
  output logic [XLEN-1:0]          rf_wdata,
  output logic                     halted,
  output logic [CNT_W-1:0]         retire_cnt,
  output logic                     busy
);
  localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  wb_entry_t          heads [NUM_CH];
  wb_entry_t          head;
  logic [NUM_CH-1:0]  full, empty, push, pop;
  logic [CW-1:0]      fifo_cnt_unused [NUM_CH];
  logic [PW-1:0]      rr_q, rr_d, gnt_idx, idx;
  logic               gnt_v, retire, we_d, halted_q, we_q, unused_ok;
  logic [REG_AW-1:0]  waddr_q;
  logic [XLEN-1:0]    wdata_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WB_DMAX-1:0] ext;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    wb_entry_t e;
    assign e = '{data: WB_DMAX'(in_data[g*XLEN +: XLEN]), rd: WB_AMAX'(in_rd[g*REG_AW +: REG_AW]),
                 mode: ld_mode_e'(in_ld_mode[g*3 +: 3]), boff: in_boff[g*2 +: 2], halt: in_halt[g]};
    assign push[g] = in_valid[g] && in_ready[g];
    assign pop[g]  = gnt_v && gnt_idx == PW'(g);
    wb_ch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst_b(rst_b), .push_i(push[g]), .din_i(e), .pop_i(pop[g]),
      .dout_o(heads[g]), .full_o(full[g]), .empty_o(empty[g]), .count_o(fifo_cnt_unused[g])
    );
  end
  assign in_ready = ~full & {NUM_CH{~halted_q}};
  assign busy = |(~empty);
  // Scan downwards so the channel closest to rr_q is the one that sticks.
  always_comb begin
    gnt_v = 1'b0;
    gnt_idx = '0;
    idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_q) + k) % NUM_CH);
      if (!empty[idx]) begin
        gnt_v = 1'b1;
        gnt_idx = idx;
      end
    end
  end
  assign head = heads[gnt_idx];
  assign rr_d = gnt_v ? (gnt_idx == PW'(NUM_CH - 1) ? '0 : gnt_idx + 1'b1) : rr_q;
  // Once halted, popped entries are flushed: no write and no count.
  assign retire = gnt_v && !halted_q;
  assign ext = wb_extend(head.data, head.mode, head.boff, XLEN);
  assign we_d = retire && !head.halt && head.rd[REG_AW-1:0] != '0;
  assign unused_ok = ^{head.rd, ext};
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      rr_q     <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rr_q     <= rr_d;
      we_q     <= we_d;
      halted_q <= halted_q | (retire && head.halt);
      cnt_q    <= cnt_q + CNT_W'(retire);
      if (retire) begin
        waddr_q <= head.rd[REG_AW-1:0];
        wdata_q <= ext[XLEN-1:0];
      end
    end
  assign rf_we      = we_q;
  assign rf_waddr   = waddr_q;
  assign rf_wdata   = wdata_q;
  assign halted     = halted_q;
  assign retire_cnt = cnt_q;
`ifdef WB_TRACE_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) cyc_q <= '0;
    else begin
      cyc_q <= cyc_q + 1'b1;
      if (retire) $display("wb_trace cyc=%0d ch=%0d rd=%0d data=%h halt=%0b",
                           cyc_q, gnt_idx, head.rd[REG_AW-1:0], ext[XLEN-1:0], head.halt);
    end
`endif
endmodule

// File: tb/tb_wb_retire_unit.sv
// tb_wb_retire_unit: directed vectors with hand-computed expectations for wb_retire_unit.
module tb_wb_retire_unit;
  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [1:0]  in_valid = '0, in_ready, in_halt = '0;
  logic [63:0] in_data = '0;
  logic [9:0]  in_rd = '0;
  logic [5:0]  in_ld_mode = '0;
  logic [3:0]  in_boff = '0;
  logic        rf_we, halted, busy;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, retire_cnt;
  int          n_chk = 0, n_pass = 0;
  int          j0, j1, got;
  logic        a0, a1, low;
  logic [4:0]  exp_rd [16];
  logic [31:0] exp_d [16];
  typedef struct {logic [31:0] d; logic [2:0] m; logic [1:0] bo; logic [31:0] e;} vec_t;
  vec_t vecs [6] = '{
    '{32'hAABB_CCDD, 3'd1, 2'd2, 32'hFFFF_FFCC},
    '{32'hAABB_CCDD, 3'd2, 2'd0, 32'h0000_00AA},
    '{32'h0000_8001, 3'd3, 2'd2, 32'hFFFF_8001},
    '{32'hAABB_CCDD, 3'd4, 2'd1, 32'h0000_AABB},
    '{32'hAABB_CCDD, 3'd2, 2'd3, 32'h0000_00DD},
    '{32'h1234_5678, 3'd1, 2'd1, 32'h0000_0034}
  };

  wb_retire_unit dut (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_rd(in_rd), .in_ld_mode(in_ld_mode), .in_boff(in_boff), .in_halt(in_halt),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .halted(halted),
    .retire_cnt(retire_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic set_ch(input int c, input logic v, input logic [31:0] d, input logic [4:0] rd,
                        input logic [2:0] m, input logic [1:0] bo, input logic h);
    in_valid[c] = v;
    in_data[c*32 +: 32] = d;
    in_rd[c*5 +: 5] = rd;
    in_ld_mode[c*3 +: 3] = m;
    in_boff[c*2 +: 2] = bo;
    in_halt[c] = h;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic one(input int c, input logic [31:0] d, input logic [4:0] rd, input logic [2:0] m,
                     input logic [1:0] bo);
    set_ch(c, 1'b1, d, rd, m, bo, 1'b0);
    tick;
    in_valid = '0;
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cnt", retire_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 2'b11);
    // single word retire: one cycle after the push edge
    set_ch(0, 1'b1, 32'h1234_5678, 5'd8, 3'd0, 2'd0, 1'b0);
    tick;
    in_valid = '0;
    chk("w_busy", busy, 1);
    chk("w_we_early", rf_we, 0);
    tick;
    chk("w_we", rf_we, 1);
    chk("w_addr", rf_waddr, 8);
    chk("w_data", rf_wdata, 32'h1234_5678);
    chk("w_cnt", retire_cnt, 1);
    chk("w_busy_end", busy, 0);
    tick;
    chk("w_we_drop", rf_we, 0);
    for (int i = 0; i < 6; i++) begin
      one(0, vecs[i].d, 5'(1 + i), vecs[i].m, vecs[i].bo);
      chk($sformatf("fmt%0d_we", i), rf_we, 1);
      chk($sformatf("fmt%0d_addr", i), rf_waddr, 5'(1 + i));
      chk($sformatf("fmt%0d_data", i), rf_wdata, vecs[i].e);
    end
    chk("fmt_cnt", retire_cnt, 7);
    one(1, 32'hDEAD_BEEF, 5'd0, 3'd0, 2'd0);
    chk("r0_we", rf_we, 0);
    chk("r0_cnt", retire_cnt, 8);
    // burst: both channels offer 8 entries each; retirement alternates ch0/ch1
    for (int k = 0; k < 16; k++) begin
      exp_rd[k] = (k % 2 == 1) ? 5'(16 + k / 2) : 5'(8 + k / 2);
      exp_d[k]  = (k % 2 == 1) ? 32'hB000_0000 + 32'(k / 2) : 32'hA000_0000 + 32'(k / 2);
    end
    j0 = 0; j1 = 0; got = 0; low = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
      set_ch(0, j0 < 8, 32'hA000_0000 + 32'(j0), 5'(8 + j0), 3'd0, 2'd0, 1'b0);
      set_ch(1, j1 < 8, 32'hB000_0000 + 32'(j1), 5'(16 + j1), 3'd0, 2'd0, 1'b0);
      @(negedge clk);
      a0 = in_valid[0] && in_ready[0];
      a1 = in_valid[1] && in_ready[1];
      if (in_ready != 2'b11) low = 1'b1;
      tick;
      if (rf_we) begin
        chk($sformatf("burst%0d_addr", got), rf_waddr, exp_rd[got]);
        chk($sformatf("burst%0d_data", got), rf_wdata, exp_d[got]);
        got++;
      end
      j0 += int'(a0);
      j1 += int'(a1);
    end
    in_valid = '0;
    chk("burst_n", got, 16);
    chk("burst_ready_low", low, 1);
    chk("burst_j0", j0, 8);
    chk("burst_j1", j1, 8);
    chk("burst_cnt", retire_cnt, 24);
    chk("burst_busy", busy, 0);
    // halt: ch0 halt is granted while three ch1 entries wait behind it
    set_ch(0, 1'b1, 32'h5555_0000, 5'd5, 3'd0, 2'd0, 1'b0);
    set_ch(1, 1'b1, 32'h6666_0001, 5'd6, 3'd0, 2'd0, 1'b0);
    tick;
    set_ch(0, 1'b1, 32'h0000_0000, 5'd9, 3'd0, 2'd0, 1'b1);
    set_ch(1, 1'b1, 32'h6666_0002, 5'd7, 3'd0, 2'd0, 1'b0);
    tick;
    chk("h_n0_we", rf_we, 1);
    chk("h_n0_addr", rf_waddr, 5);
    set_ch(0, 1'b0, 32'h0, 5'd0, 3'd0, 2'd0, 1'b0);
    set_ch(1, 1'b1, 32'h6666_0003, 5'd10, 3'd0, 2'd0, 1'b0);
    tick;
    chk("h_e1_we", rf_we, 1);
    chk("h_e1_addr", rf_waddr, 6);
    set_ch(1, 1'b1, 32'h6666_0004, 5'd11, 3'd0, 2'd0, 1'b0);
    tick;
    in_valid = '0;
    chk("h_halted", halted, 1);
    chk("h_ready", in_ready, 2'b00);
    chk("h_we", rf_we, 0);
    chk("h_cnt", retire_cnt, 27);
    chk("h_busy", busy, 1);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("flush%0d_we", k), rf_we, 0);
    end
    chk("flush_busy", busy, 0);
    chk("flush_halted", halted, 1);
    // async reset with two entries queued
    rst_b = 1'b0;
    tick;
    rst_b = 1'b1;
    chk("rr_halted", halted, 0);
    set_ch(0, 1'b1, 32'h0000_0001, 5'd12, 3'd0, 2'd0, 1'b0);
    set_ch(1, 1'b1, 32'h0000_0002, 5'd13, 3'd0, 2'd0, 1'b0);
    tick;
    set_ch(0, 1'b1, 32'h0000_0003, 5'd14, 3'd0, 2'd0, 1'b0);
    in_valid[1] = 1'b0;
    tick;
    in_valid = '0;
    chk("ar_pre_we", rf_we, 1);
    chk("ar_pre_data", rf_wdata, 1);
    chk("ar_pre_cnt", retire_cnt, 1);
    chk("ar_pre_busy", busy, 1);
    #3 rst_b = 1'b0;
    #1;
    chk("ar_we", rf_we, 0);
    chk("ar_addr", rf_waddr, 0);
    chk("ar_data", rf_wdata, 0);
    chk("ar_cnt", retire_cnt, 0);
    chk("ar_busy", busy, 0);
    tick;
    chk("ar_edge_we", rf_we, 0);
    chk("ar_edge_cnt", retire_cnt, 0);
    rst_b = 1'b1;
    chk("ar_rel_ready", in_ready, 2'b11);
    chk("ar_rel_busy", busy, 0);
    tick;
    chk("ar_post_we", rf_we, 0);
    chk("ar_post_cnt", retire_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
